ram_data_tester: RTL and testbench

RAM_DATA_TESTER -- requirements
Module: ram_data_tester

---
 rtl/ram_data_tester.sv | 46 ++++
 tb/tb_ram_data_tester.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ram_data_tester.sv
// rtl/ram_data_tester.sv - pattern-generating RAM tester; optional write-through via RAM_WRITE_THROUGH_EN
module ram_data_tester #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              we,
   output logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] out
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Test pattern is the inverted address; purely combinational so it tracks address immediately
   assign data = ~address;

   // Storage array: cleared the moment rst rises, otherwise written with the pattern on we
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[address] <= data;
      end
   end

   // Registered read port: loads on read cycles; on write cycles it holds or shows the written word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= '0;
      end else if (!we) begin
         out <= mem[address];
      end
`ifdef RAM_WRITE_THROUGH_EN
      else begin
         out <= data;
      end
`endif
   end

endmodule

// File: tb/tb_ram_data_tester.sv
// tb/tb_ram_data_tester.sv - randomized bench for ram_data_tester against an array reference model
module tb_ram_data_tester;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int MAXW  = 15;

   logic          clk;
   logic          rst;
   logic [AW-1:0] address;
   logic          we;
   logic [AW-1:0] data;
   logic [AW-1:0] out;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   int m_mem [DEPTH];
   int m_out;

   ram_data_tester #(.ADDR_W(AW), .DATA_W(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .we      (we),
      .data    (data),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_out = 0;
   endfunction

   // One clock of operation, entered and left on a falling edge
   task automatic do_cycle(input int a, input bit w, input string tag);
      address = a[AW-1:0];
      we      = w;
      #1;
      check({tag, "_data"}, {28'd0, data}, MAXW - a);
      @(posedge clk);
      if (w) begin
         m_mem[a] = MAXW - a;
`ifdef RAM_WRITE_THROUGH_EN
         m_out = MAXW - a;
`endif
      end else begin
         m_out = m_mem[a];
      end
      @(negedge clk);
      check({tag, "_out"}, {28'd0, out}, m_out);
   endtask

   initial begin
      rst     = 1'b1;
      address = '0;
      we      = 1'b0;
      model_reset();

      // Reset holds out at zero before and across the first edge
      #3;
      check("rst_out_early", {28'd0, out}, 0);
      #9;
      check("rst_out_12ns", {28'd0, out}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Every word reads zero after reset
      for (int a = 0; a < DEPTH; a++) do_cycle(a, 1'b0, "rst_read");

      // Pattern sweep, combinational
      for (int a = 0; a < DEPTH; a++) begin
         address = a[AW-1:0];
         #1;
         check("pattern", {28'd0, data}, MAXW - a);
      end
      @(negedge clk);

      // Write/read sequence: two write clocks then two read clocks per address 0..3
      for (int a = 0; a < 4; a++) begin
         do_cycle(a, 1'b1, "seq_wr");
         do_cycle(a, 1'b1, "seq_wr");
         do_cycle(a, 1'b0, "seq_rd");
         do_cycle(a, 1'b0, "seq_rd");
         check("seq_word", {28'd0, out}, MAXW - a);
      end

      // Write of address 5 while out is zero
      do_cycle(9, 1'b0, "pre5_rd");
      check("pre5_zero", {28'd0, out}, 0);
      do_cycle(5, 1'b1, "wr5");
`ifdef RAM_WRITE_THROUGH_EN
      check("wr5_out", {28'd0, out}, 4'hA);
`else
      check("wr5_out", {28'd0, out}, 0);
`endif
      do_cycle(5, 1'b0, "rd5");
      check("rd5_word", {28'd0, out}, 4'hA);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         do_cycle(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)), "rand");
      end

      // Mid-operation reset between edges
      for (int a = 0; a < 4; a++) do_cycle(a, 1'b1, "mid_wr");
      do_cycle(1, 1'b0, "mid_pre");
      check("mid_pre_word", {28'd0, out}, 4'hE);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out", {28'd0, out}, 0);
      model_reset();
      #1;
      rst = 1'b0;
      @(negedge clk);
      do_cycle(2, 1'b0, "mid_rd2");
      check("mid_rd2_word", {28'd0, out}, 0);

      // Writes attempted while reset is held across an edge are dropped
      address = 4'd7;
      we      = 1'b1;
      rst     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_wr_out", {28'd0, out}, 0);
      rst = 1'b0;
      do_cycle(7, 1'b0, "rst_wr_rd");
      check("rst_wr_word", {28'd0, out}, 0);

      // First edge after reset release operates normally
      do_cycle(12, 1'b1, "post_wr");
      do_cycle(12, 1'b0, "post_rd");
      check("post_word", {28'd0, out}, 4'h3);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
